// File: rtl/csi_ph_ecc_engine.sv
// MIPI CSI-2 packet-header ECC engine (Hamming 24->6, modified SEC-DED), NUM_CH headers per beat.
// Error counters are built only when CSI_PH_ECC_CNT_EN is defined; otherwise they read as zero.
module csi_ph_ecc_engine #(
    parameter int NUM_CH      = 1,
    parameter int MODE        = 0,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [32*NUM_CH-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [32*NUM_CH-1:0]  m_data,
    output logic [NUM_CH-1:0]     m_corr,
    output logic [NUM_CH-1:0]     m_uncorr,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt
);

    // Column codes, d23 in the top slice down to d0 in the bottom slice.
    localparam logic [143:0] COLS = {
        6'h3B, 6'h37, 6'h2F, 6'h1F,
        6'h38, 6'h34, 6'h32, 6'h31, 6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23,
        6'h1C, 6'h1A, 6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
    };

    function automatic logic [5:0] calc_parity(input logic [23:0] d);
        logic [5:0] h;
        h = 6'h00;
        for (int i = 0; i < 24; i++) begin
            h = h ^ ({6{d[i]}} & COLS[6*i +: 6]);
        end
        return h;
    endfunction

    // Generate mode carries the parity itself; check mode carries the syndrome.
    function automatic logic [5:0] calc_code(input logic [31:0] w);
        logic [5:0] code;
        if (MODE == 0) begin
            code = calc_parity(w[23:0]);
        end else begin
            code = calc_parity(w[23:0]) ^ w[29:24];
        end
        return code;
    endfunction

    // Returns {uncorr, corr, word}.
    function automatic logic [33:0] fix_word(input logic [31:0] w, input logic [5:0] code);
        logic [23:0] d;
        logic        hit;
        logic        hit_i;
        logic        corr;
        logic        unc;
        logic [31:0] o;
        d   = w[23:0];
        hit = 1'b0;
        for (int i = 0; i < 24; i++) begin
            hit_i = (code == COLS[6*i +: 6]);
            d[i]  = d[i] ^ hit_i;
            hit   = hit | hit_i;
        end
        if (MODE == 0) begin
            corr = 1'b0;
            unc  = 1'b0;
            o    = {2'b00, code, w[23:0]};
        end else if (code == 6'h00) begin
            corr = 1'b0;
            unc  = 1'b0;
            o    = w;
        end else if ((code & (code - 6'h01)) == 6'h00) begin
            corr = 1'b1;
            unc  = 1'b0;
            o    = {w[31:30], calc_parity(w[23:0]), w[23:0]};
        end else if (hit) begin
            corr = 1'b1;
            unc  = 1'b0;
            o    = {w[31:30], calc_parity(d), d};
        end else begin
            corr = 1'b0;
            unc  = 1'b1;
            o    = w;
        end
        return {unc, corr, o};
    endfunction

    logic [6*NUM_CH-1:0]  code_in;
    logic [32*NUM_CH-1:0] src_data;
    logic [6*NUM_CH-1:0]  src_code;
    logic                 src_valid;
    logic                 out_load;
    logic [32*NUM_CH-1:0] fixed_data;
    logic [NUM_CH-1:0]    fixed_corr;
    logic [NUM_CH-1:0]    fixed_unc;
    logic                 out_hs;

    assign out_load = !m_valid || m_ready;
    assign out_hs   = m_valid && m_ready;

    // Per-channel parity / syndrome of the incoming beat.
    always_comb begin
        code_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            code_in[6*c +: 6] = calc_code(s_data[32*c +: 32]);
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic                 s1_valid;
            logic                 s1_load;
            logic [32*NUM_CH-1:0] s1_data;
            logic [6*NUM_CH-1:0]  s1_code;

            assign s1_load = !s1_valid || out_load;
            assign s_ready = s1_load;

            // Stage 1: header word plus its syndrome.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_code  <= '0;
                end else if (s1_load) begin
                    s1_valid <= s_valid;
                    if (s_valid) begin
                        s1_data <= s_data;
                        s1_code <= code_in;
                    end
                end
            end

            assign src_valid = s1_valid;
            assign src_data  = s1_data;
            assign src_code  = s1_code;
        end else begin : g_pipe1
            assign s_ready   = out_load;
            assign src_valid = s_valid;
            assign src_data  = s_data;
            assign src_code  = code_in;
        end
    endgenerate

    // Correction and output ECC regeneration, per channel.
    always_comb begin
        fixed_data = '0;
        fixed_corr = '0;
        fixed_unc  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            {fixed_unc[c], fixed_corr[c], fixed_data[32*c +: 32]} =
                fix_word(src_data[32*c +: 32], src_code[6*c +: 6]);
        end
    end

    // Output register stage; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_corr   <= '0;
            m_uncorr <= '0;
        end else if (out_load) begin
            m_valid <= src_valid;
            if (src_valid) begin
                m_data   <= fixed_data;
                m_corr   <= fixed_corr;
                m_uncorr <= fixed_unc;
            end
        end
    end

`ifdef CSI_PH_ECC_CNT_EN
    // Saturating beat counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if ((|m_corr) && !(&corr_cnt)) begin
                corr_cnt <= corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((|m_uncorr) && !(&uncorr_cnt)) begin
                uncorr_cnt <= uncorr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clr ^ out_hs;
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif

endmodule

// File: doc/csi_ph_ecc_engine.md
Name: csi_ph_ecc_engine

Overview:
- Pipelined MIPI CSI-2 packet-header ECC engine (Hamming 24→6, modified SEC-DED) with a valid/ready stream in and out.
- MODE=0 (generate): computes ECC and inserts it into the header word.
- MODE=1 (check): computes the syndrome, corrects single-bit errors and flags uncorrectable headers.
- Processes NUM_CH headers per beat. Sits between the CSI header framer/deframer and the gearbox DMA.

Parameters:
- NUM_CH, 1, headers per beat (1..4).
- MODE, 0, 0 = generate, 1 = check/correct.
- PIPE_STAGES, 1, register stages (1 or 2). Latency in cycles.
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&&s_ready
- s_data  in  32*NUM_CH  per channel c, bits [32c+31:32c] = {ecc[7:0], byte_2, byte_1, byte_0}; ecc is ignored when MODE=0
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  32*NUM_CH  same layout; corrected data and ECC
- m_corr  out  NUM_CH  per-channel single-bit error corrected (MODE=1 only, else 0)
- m_uncorr  out  NUM_CH  per-channel uncorrectable error (MODE=1 only, else 0)
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  beats with any m_corr bit set
- uncorr_cnt  out  CNT_W  beats with any m_uncorr bit set

Behaviour:
- Reset (asynchronous, rst=1): every stage valid=0, m_valid=0, m_data=0, m_corr=0, m_uncorr=0, counters=0. s_ready=1 after reset. Reset mid-stream discards all in-flight beats.
- Parity h[5:0]: h[k] = XOR of data bits d_i (d0 = byte_0[0] … d23 = byte_2[7]) whose column code has bit k set. Column codes, d0..d23:
  - d0..d9: 07 0B 0D 0E 13 15 16 19 1A 1C
  - d10..d19: 23 25 26 29 2A 2C 31 32 34 38
  - d20..d23: 1F 2F 37 3B
- Generate (MODE=0): out ecc = {2'b00, h}. Data bytes pass through unchanged.
- Check (MODE=1):
  - syn = h ^ ecc_in[5:0].
  - syn==0: no error.
  - syn equals a column code i: flip d_i, set m_corr.
  - syn has exactly one bit set: ECC-bit error. Data is unchanged and m_corr is set.
  - Any other syn: uncorrectable. Data and ECC pass through unmodified and m_uncorr is set.
  - Output ecc[5:0] = recomputed h of the (corrected) data. ecc[7:6] pass through from input.
- Pipeline:
  - PIPE_STAGES=1: parity, syndrome and correction are registered once. Latency 1.
  - PIPE_STAGES=2: syndrome is registered in stage 1; correction and output ECC are registered in stage 2. Latency 2.
  - Each stage loads when it is empty or the next stage accepts. s_ready = !stage1_valid || stage1_advances (no combinational path m_ready→s_ready is allowed only within this rule).
  - Full throughput: 1 beat/cycle while m_ready=1.
- Stall: while m_valid && !m_ready, m_data, m_corr and m_uncorr hold stable and no stage advances.
- Counters:
  - Increment on the output handshake (m_valid&&m_ready) when |m_corr or |m_uncorr respectively.
  - They saturate at all-ones (no wrap).
  - cnt_clr takes priority over a simultaneous increment.
- Channels are independent. Any mix of clean, corrected and uncorrectable channels is allowed within one beat.

Optional Feature:
- CSI_PH_ECC_CNT_EN defined: corr_cnt/uncorr_cnt counters are implemented as specified above.
- Not defined: counter registers are not synthesised, corr_cnt and uncorr_cnt are tied to 0, and cnt_clr is ignored. Ports remain in both builds.

Test Plan:
- MODE=0, NUM_CH=1, s_data[23:0]=0x0F002B → m_data=0x180F002B one cycle later (PIPE_STAGES=1); s_data[23:0]=0 → m_data=0x00000000.
- MODE=1, input 0x180F002A (d0 flipped) → m_data=0x180F002B, m_corr=1; input 0x190F002B (ECC bit0 flipped) → m_data=0x180F002B, m_corr=1, m_uncorr=0.
- MODE=1, input 0x180F0028 (d0,d1 flipped, syn=0x0C) → m_uncorr=1, m_corr=0, m_data=0x180F0028; uncorr_cnt=1 (macro defined) or 0 (undefined).
- MODE=1, NUM_CH=2, PIPE_STAGES=2, back-to-back beats with m_ready toggling 1,0,0,1 → no beat lost or duplicated; m_data stable during stall; output order preserved; latency 2 cycles.
- Assert rst for 1 cycle with 2 beats in flight → m_valid=0 immediately, counters=0, next accepted beat emerges correctly.
- CNT_W=2, 5 corrected beats, then cnt_clr asserted with a corrected beat in the same cycle → corr_cnt saturates at 3, then reads 0.
